// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width limits for the counter and the FIFO pointer logic.
package gray_pkg;

  localparam int N_MIN     = 2;
  localparam int N_MAX     = 16;
  localparam int N_DEFAULT = 4;

  function automatic logic [N_MAX-1:0] bin2gray(input logic [N_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [N_MAX-1:0] gray2bin(input logic [N_MAX-1:0] g);
    logic [N_MAX-1:0] b;
    b[N_MAX-1] = g[N_MAX-1];
    for (int i = N_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_ptr_counter_if.sv
// Control and status bundle of gray_ptr_counter; the dec line exists only with GRAY_PTR_DEC_EN.
interface gray_ptr_counter_if
  import gray_pkg::*;
#(
  parameter int N = N_DEFAULT
);

  logic         inc;
`ifdef GRAY_PTR_DEC_EN
  logic         dec;
`endif
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] bin;
  logic [N-1:0] gray;
  logic [N-1:0] gray_next;
  logic         wrap;
  logic         at_zero;

  modport master (
`ifdef GRAY_PTR_DEC_EN
    output dec,
`endif
    output inc, load, load_val,
    input  bin, gray, gray_next, wrap, at_zero
  );

  modport slave (
`ifdef GRAY_PTR_DEC_EN
    input  dec,
`endif
    input  inc, load, load_val,
    output bin, gray, gray_next, wrap, at_zero
  );

endinterface

// File: rtl/gray_ptr_counter_gray_encode.sv
// Combinational binary-to-Gray encoder; output bit i is bin[i+1] ^ bin[i], MSB passes through.
module gray_encode
  import gray_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  assign gray[N-1] = bin[N-1];

  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_bit
      assign gray[gi] = bin[gi+1] ^ bin[gi];
    end
  endgenerate

endmodule

// File: rtl/gray_ptr_counter.sv
// Binary/Gray pointer counter with load, wrap pulse and zero flag.
// Define GRAY_PTR_DEC_EN to compile in the dec input and down-counting.
module gray_ptr_counter
  import gray_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int RST_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  gray_ptr_counter_if.slave bus
);

  localparam logic [N-1:0] RST_BIN  = N'(RST_VAL);
  localparam logic [N-1:0] RST_GRAY = N'(bin2gray(N_MAX'(RST_VAL)));

  logic [N-1:0] bin_reg;
  logic [N-1:0] bin_next;
  logic [N-1:0] gray_reg;
  logic [N-1:0] gray_next_w;
  logic         wrap_reg;
  logic         wrap_next;
  logic         at_zero_reg;
  logic         step_up;
  logic         step_down;

`ifdef GRAY_PTR_DEC_EN
  // Simultaneous inc and dec cancel out and the count holds.
  assign step_up   = bus.inc & ~bus.dec;
  assign step_down = bus.dec & ~bus.inc;
`else
  assign step_up   = bus.inc;
  assign step_down = 1'b0;
`endif

  // Reset is folded in here too so gray_next always shows the value the next edge loads.
  always_comb begin
    bin_next  = bin_reg;
    wrap_next = 1'b0;
    if (rst) begin
      bin_next = RST_BIN;
    end else if (bus.load) begin
      bin_next = bus.load_val;
    end else if (step_up) begin
      bin_next  = bin_reg + N'(1);
      wrap_next = &bin_reg;
    end else if (step_down) begin
      bin_next  = bin_reg - N'(1);
      wrap_next = ~|bin_reg;
    end
  end

  gray_encode #(.N(N)) u_gray_encode (
    .bin  (bin_next),
    .gray (gray_next_w)
  );

  // gray is loaded straight from the encoder so the flop outputs never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg     <= RST_BIN;
      gray_reg    <= RST_GRAY;
      wrap_reg    <= 1'b0;
      at_zero_reg <= (RST_BIN == '0);
    end else begin
      bin_reg     <= bin_next;
      gray_reg    <= gray_next_w;
      wrap_reg    <= wrap_next;
      at_zero_reg <= (bin_next == '0);
    end
  end

  assign bus.bin       = bin_reg;
  assign bus.gray      = gray_reg;
  assign bus.gray_next = gray_next_w;
  assign bus.wrap      = wrap_reg;
  assign bus.at_zero   = at_zero_reg;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Self-checking bench: four counter instances (N=4/RST 0, N=4/RST 5, N=2, N=8) against an arithmetic model.
module tb_gray_ptr_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_ptr_counter_if #(.N(4)) if_a ();
  gray_ptr_counter_if #(.N(4)) if_b ();
  gray_ptr_counter_if #(.N(2)) if_c ();
  gray_ptr_counter_if #(.N(8)) if_d ();

  gray_ptr_counter #(.N(4), .RST_VAL(0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  gray_ptr_counter #(.N(4), .RST_VAL(5)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  gray_ptr_counter #(.N(2), .RST_VAL(0)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  gray_ptr_counter #(.N(8), .RST_VAL(0)) dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

  logic        inc_d  [4];
  logic        dec_d  [4];
  logic        load_d [4];
  logic [15:0] lv     [4];

  logic [15:0] obs_bin [4];
  logic [15:0] obs_gray[4];
  logic [15:0] obs_gn  [4];
  logic        obs_wrap[4];
  logic        obs_z   [4];

  assign if_a.inc = inc_d[0];  assign if_a.load = load_d[0];  assign if_a.load_val = lv[0][3:0];
  assign if_b.inc = inc_d[1];  assign if_b.load = load_d[1];  assign if_b.load_val = lv[1][3:0];
  assign if_c.inc = inc_d[2];  assign if_c.load = load_d[2];  assign if_c.load_val = lv[2][1:0];
  assign if_d.inc = inc_d[3];  assign if_d.load = load_d[3];  assign if_d.load_val = lv[3][7:0];
`ifdef GRAY_PTR_DEC_EN
  assign if_a.dec = dec_d[0];
  assign if_b.dec = dec_d[1];
  assign if_c.dec = dec_d[2];
  assign if_d.dec = dec_d[3];
`endif

  assign obs_bin[0] = 16'(if_a.bin);  assign obs_gray[0] = 16'(if_a.gray);  assign obs_gn[0] = 16'(if_a.gray_next);
  assign obs_bin[1] = 16'(if_b.bin);  assign obs_gray[1] = 16'(if_b.gray);  assign obs_gn[1] = 16'(if_b.gray_next);
  assign obs_bin[2] = 16'(if_c.bin);  assign obs_gray[2] = 16'(if_c.gray);  assign obs_gn[2] = 16'(if_c.gray_next);
  assign obs_bin[3] = 16'(if_d.bin);  assign obs_gray[3] = 16'(if_d.gray);  assign obs_gn[3] = 16'(if_d.gray_next);
  assign obs_wrap[0] = if_a.wrap;  assign obs_z[0] = if_a.at_zero;
  assign obs_wrap[1] = if_b.wrap;  assign obs_z[1] = if_b.at_zero;
  assign obs_wrap[2] = if_c.wrap;  assign obs_z[2] = if_c.at_zero;
  assign obs_wrap[3] = if_d.wrap;  assign obs_z[3] = if_d.at_zero;

  // Reference model: plain modular integers, Gray computed as b ^ (b >> 1).
  int          nn[4] = '{4, 4, 2, 8};
  int unsigned rv[4] = '{0, 5, 0, 0};
  int unsigned mb[4];
  int unsigned nb[4];
  logic        mw[4];
  logic        nw[4];
  logic        stepped[4];
  logic [15:0] prev_g[4];

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] gref(input int unsigned b);
    return 16'(b ^ (b >> 1));
  endfunction

  task automatic chk(input string tag, input int idx, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s[%0d] got %0h expected %0h", tag, idx, got, exp);
    end
  endtask

  task automatic predict();
    for (int i = 0; i < 4; i++) begin
      int unsigned m;
      logic up, down;
      m    = 32'd1 << nn[i];
      up   = inc_d[i] && !dec_d[i];
      down = dec_d[i] && !inc_d[i];
      stepped[i] = 1'b0;
      nw[i] = 1'b0;
      if (rst) nb[i] = rv[i];
      else if (load_d[i]) nb[i] = int'(lv[i]);
      else if (up) begin
        nw[i] = (mb[i] == m - 1);
        nb[i] = (mb[i] + 1) % m;
        stepped[i] = 1'b1;
      end else if (down) begin
        nw[i] = (mb[i] == 0);
        nb[i] = (mb[i] + m - 1) % m;
        stepped[i] = 1'b1;
      end else nb[i] = mb[i];
    end
  endtask

  // Inputs were driven just after the previous edge; check gray_next, clock, then check outputs.
  task automatic cycle();
    #1;
    predict();
    for (int i = 0; i < 4; i++) begin
      chk("gray_next", i, obs_gn[i], gref(nb[i]));
      prev_g[i] = obs_gray[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      mb[i] = nb[i];
      mw[i] = nw[i];
      chk("bin", i, obs_bin[i], 16'(mb[i]));
      chk("gray", i, obs_gray[i], gref(mb[i]));
      chk("wrap", i, 16'(obs_wrap[i]), 16'(mw[i]));
      chk("at_zero", i, 16'(obs_z[i]), 16'(mb[i] == 0));
      if (stepped[i]) chk("gray_1bit", i, 16'($countones(obs_gray[i] ^ prev_g[i])), 16'd1);
    end
  endtask

  task automatic drive_all(input logic inc, input logic dec, input logic load, input int unsigned val);
    for (int i = 0; i < 4; i++) begin
      inc_d[i]  = inc;
      dec_d[i]  = dec;
      load_d[i] = load;
      lv[i]     = 16'(val % (32'd1 << nn[i]));
    end
  endtask

  int unsigned gseq[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  initial begin
    for (int i = 0; i < 4; i++) begin
      mb[i] = 0;
      mw[i] = 1'b0;
    end
    drive_all(1'b0, 1'b0, 1'b0, 0);

    // Two reset cycles
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_bin_a", 0, obs_bin[0], 16'h0);
    chk("rst_gray_a", 0, obs_gray[0], 16'h0);
    chk("rst_zero_a", 0, 16'(obs_z[0]), 16'h1);
    chk("rst_wrap_a", 0, 16'(obs_wrap[0]), 16'h0);
    chk("rst_bin_b", 1, obs_bin[1], 16'h5);
    chk("rst_zero_b", 1, 16'(obs_z[1]), 16'h0);
    rst = 1'b0;

    // Full up-count lap with a wrap on the last step
    drive_all(1'b1, 1'b0, 1'b0, 0);
    for (int s = 0; s < 16; s++) begin
      cycle();
      chk("seq_gray_a", s, obs_gray[0], 16'(gseq[s]));
      chk("seq_wrap_a", s, 16'(obs_wrap[0]), 16'(s == 15));
    end

    // Load wins over inc and suppresses wrap
    drive_all(1'b1, 1'b0, 1'b1, 9);
    cycle();
    chk("load_bin_a", 0, obs_bin[0], 16'd9);
    chk("load_gray_a", 0, obs_gray[0], 16'b1101);
    chk("load_wrap_a", 0, 16'(obs_wrap[0]), 16'h0);
    drive_all(1'b1, 1'b0, 1'b0, 0);
    cycle();
    chk("inc_bin_a", 0, obs_bin[0], 16'd10);
    chk("inc_gray_a", 0, obs_gray[0], 16'b1111);

`ifdef GRAY_PTR_DEC_EN
    // Down-wrap from zero, then inc+dec holds
    drive_all(1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive_all(1'b0, 1'b1, 1'b0, 0);
    cycle();
    chk("dec_bin_a", 0, obs_bin[0], 16'd15);
    chk("dec_gray_a", 0, obs_gray[0], 16'b1000);
    chk("dec_wrap_a", 0, 16'(obs_wrap[0]), 16'h1);
    drive_all(1'b1, 1'b1, 1'b0, 0);
    cycle();
    chk("hold_bin_a", 0, obs_bin[0], 16'd15);
    chk("hold_wrap_a", 0, 16'(obs_wrap[0]), 16'h0);
`endif

    // Reset overrides load and inc mid-count (instance b, RST_VAL=5)
    drive_all(1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive_all(1'b1, 1'b0, 1'b0, 0);
    cycle();
    cycle();
    chk("cnt_bin_b", 1, obs_bin[1], 16'd7);
    rst = 1'b1;
    drive_all(1'b1, 1'b0, 1'b1, 12);
    cycle();
    chk("ovr_bin_b", 1, obs_bin[1], 16'd5);
    chk("ovr_gray_b", 1, obs_gray[1], 16'b0111);
    chk("ovr_zero_b", 1, 16'(obs_z[1]), 16'h0);
    rst = 1'b0;
    drive_all(1'b1, 1'b0, 1'b0, 0);
    cycle();
    chk("resume_bin_b", 1, obs_bin[1], 16'd6);

    // Random inc/dec/load with occasional reset
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++) begin
        inc_d[i]  = $urandom_range(0, 1) == 1;
`ifdef GRAY_PTR_DEC_EN
        dec_d[i]  = $urandom_range(0, 1) == 1;
`else
        dec_d[i]  = 1'b0;
`endif
        load_d[i] = ($urandom_range(0, 7) == 0);
        lv[i]     = 16'($urandom_range(0, (1 << nn[i]) - 1));
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
